mcm_block_accumulator: RTL and testbench

MCM_BLOCK_ACCUMULATOR -- requirements
Module: mcm_block_accumulator

---
 rtl/mcm_acc_pkg.sv | 30 +++
 rtl/mcm_acc_sat_add.sv | 42 ++++
 rtl/mcm_block_accumulator.sv | 95 +++++++++
 tb/tb_mcm_block_accumulator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mcm_acc_pkg.sv
// Shared types, default widths and sign-extend / saturate helpers for the block accumulator.
// Helpers work at MAX_W bits so one definition serves any ACC_W/DATA_W below MAX_W.
package mcm_acc_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_ACC_W     = 40;
   localparam int DEF_BLOCK_LEN = 16;
   localparam int MAX_W         = 128;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } acc_state_t;

   function automatic logic signed [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] v, input int w);
      logic signed [MAX_W-1:0] t;
      t = $signed(v << (MAX_W - w));
      return t >>> (MAX_W - w);
   endfunction

   // Most positive (neg=0) or most negative (neg=1) value of a w-bit signed number.
   function automatic logic signed [MAX_W-1:0] sat_limit(input logic neg, input int w);
      logic signed [MAX_W-1:0] one;
      logic signed [MAX_W-1:0] mag;
      one = {{(MAX_W-1){1'b0}}, 1'b1};
      mag = one << (w - 1);
      return neg ? -mag : mag - one;
   endfunction

endpackage

// File: rtl/mcm_acc_sat_add.sv
// Combinational accumulate step: acc + sign-extended din with overflow flag.
// Clamps on overflow when MCM_ACC_SATURATE_EN is defined, otherwise wraps modulo 2^ACC_W.
module mcm_acc_sat_add
   import mcm_acc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [DATA_W-1:0] din,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic signed [MAX_W-1:0] acc_x;
   logic signed [MAX_W-1:0] din_x;
   logic signed [MAX_W-1:0] sum_x;
   logic signed [MAX_W-1:0] lim_hi;
   logic signed [MAX_W-1:0] lim_lo;

   // The exact sum at MAX_W can never itself overflow, so range compares give the flag.
   always_comb begin
      acc_x  = sign_ext({{(MAX_W-ACC_W){1'b0}}, acc}, ACC_W);
      din_x  = sign_ext({{(MAX_W-DATA_W){1'b0}}, din}, DATA_W);
      sum_x  = acc_x + din_x;
      lim_hi = sat_limit(1'b0, ACC_W);
      lim_lo = sat_limit(1'b1, ACC_W);
      ovf    = (sum_x > lim_hi) || (sum_x < lim_lo);
`ifdef MCM_ACC_SATURATE_EN
      if (sum_x > lim_hi) begin
         sum = lim_hi[ACC_W-1:0];
      end else if (sum_x < lim_lo) begin
         sum = lim_lo[ACC_W-1:0];
      end else begin
         sum = sum_x[ACC_W-1:0];
      end
`else
      sum = sum_x[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/mcm_block_accumulator.sv
// Sums BLOCK_LEN signed products per result and holds each result until taken downstream.
// Optional MCM_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_ACCUM | accepting samples, acc/cnt advance on each accept
// ST_HOLD  | block result on out_data, waiting for out_ready
module mcm_block_accumulator
   import mcm_acc_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int BLOCK_LEN = DEF_BLOCK_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_data,
   input  logic              out_ready,
   output logic              out_ovf
);

   localparam int              CNT_W    = $clog2(BLOCK_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

   acc_state_t       state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             add_ovf;
   logic             accept;

   assign in_ready = rst_n && ((state == ST_ACCUM) || out_ready);
   assign accept   = in_valid && in_ready;

   // acc is cleared when a block completes, so in HOLD the adder already sees the next block's base.
   mcm_acc_sat_add #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_sat_add (
      .acc (acc),
      .din (in_data),
      .sum (acc_sum),
      .ovf (add_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else begin
         unique case (state)
            ST_ACCUM: begin
               if (accept) begin
                  if (cnt == CNT_LAST) begin
                     out_data  <= acc_sum;
                     out_ovf   <= ovf | add_ovf;
                     out_valid <= 1'b1;
                     state     <= ST_HOLD;
                     acc       <= '0;
                     cnt       <= '0;
                     ovf       <= 1'b0;
                  end else begin
                     acc <= acc_sum;
                     cnt <= cnt + 1'b1;
                     ovf <= ovf | add_ovf;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_ACCUM;
                  if (accept) begin
                     acc <= acc_sum;
                     cnt <= CNT_W'(1);
                     ovf <= add_ovf;
                  end
               end
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_mcm_block_accumulator.sv
// Directed bench for mcm_block_accumulator: BLOCK_LEN=4 at ACC_W=40 and ACC_W=33 side by side.
// Expected overflow values follow MCM_ACC_SATURATE_EN when it is defined.
module tb_mcm_block_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [39:0] out_data;
   logic        out_ovf;

   logic        in_ready_33;
   logic        out_valid_33;
   logic [32:0] out_data_33;
   logic        out_ovf_33;

   int checks = 0;
   int errors = 0;

   mcm_block_accumulator #(.DATA_W(32), .ACC_W(40), .BLOCK_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_ovf   (out_ovf)
   );

   mcm_block_accumulator #(.DATA_W(32), .ACC_W(33), .BLOCK_LEN(4)) dut_33 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready_33),
      .out_valid (out_valid_33),
      .out_data  (out_data_33),
      .out_ready (out_ready),
      .out_ovf   (out_ovf_33)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one sample and return 1 time unit after the edge that accepted it.
   task automatic push(input logic [31:0] d);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_val("push_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      #12;
      check_val("rst_out_valid", out_valid, 64'd0);
      check_val("rst_out_data", out_data, 64'd0);
      check_val("rst_out_ovf", out_ovf, 64'd0);
      check_val("rst_in_ready", in_ready, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back 1,2,3,4
      push(32'd1);
      push(32'd2);
      push(32'd3);
      check_val("b2b_no_early_valid", out_valid, 64'd0);
      push(32'd4);
      check_val("b2b_valid", out_valid, 64'd1);
      check_val("b2b_data", out_data, 64'd10);
      check_val("b2b_ovf", out_ovf, 64'd0);
      @(posedge clk);
      #1;
      check_val("b2b_retired", out_valid, 64'd0);

      // -5,3,-7,1 with two-cycle gaps
      push(-32'sd5);
      repeat (2) @(posedge clk);
      #1;
      push(32'd3);
      repeat (2) @(posedge clk);
      #1;
      push(-32'sd7);
      repeat (2) @(posedge clk);
      #1;
      check_val("gap_no_early_valid", out_valid, 64'd0);
      push(32'd1);
      check_val("gap_valid", out_valid, 64'd1);
      check_val("gap_data", out_data, 64'h0000_00FF_FFFF_FFF8);
      check_val("gap_data_33", out_data_33, 64'h0000_0001_FFFF_FFF8);
      check_val("gap_ovf", out_ovf, 64'd0);

      // backpressure: hold result for 5 cycles with next sample waiting
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      push(32'd5);
      push(32'd6);
      push(32'd7);
      push(32'd8);
      in_valid = 1'b1;
      in_data  = 32'd100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("hold_valid", out_valid, 64'd1);
         check_val("hold_data", out_data, 64'd26);
         check_val("hold_in_ready", in_ready, 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check_val("hold_release_in_ready", in_ready, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_val("hold_retired", out_valid, 64'd0);
      push(32'd1);
      push(32'd1);
      check_val("no_bubble_pending", out_valid, 64'd0);
      push(32'd1);
      check_val("no_bubble_valid", out_valid, 64'd1);
      check_val("no_bubble_data", out_data, 64'd103);

      // positive overflow at ACC_W=33
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) push(32'h7FFF_FFFF);
      check_val("pos_data_40", out_data, 64'h0000_0001_FFFF_FFFC);
      check_val("pos_ovf_40", out_ovf, 64'd0);
`ifdef MCM_ACC_SATURATE_EN
      check_val("pos_data_33", out_data_33, 64'h0000_0000_FFFF_FFFF);
`else
      check_val("pos_data_33", out_data_33, 64'h0000_0001_FFFF_FFFC);
`endif
      check_val("pos_ovf_33", out_ovf_33, 64'd1);

      // negative overflow at ACC_W=33; second sample lands exactly on the minimum
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) push(32'h8000_0000);
      check_val("neg_data_40", out_data, 64'h0000_00FE_0000_0000);
      check_val("neg_ovf_40", out_ovf, 64'd0);
`ifdef MCM_ACC_SATURATE_EN
      check_val("neg_data_33", out_data_33, 64'h0000_0001_0000_0000);
`else
      check_val("neg_data_33", out_data_33, 64'd0);
`endif
      check_val("neg_ovf_33", out_ovf_33, 64'd1);

      // reset mid-block discards the partial sum
      @(posedge clk);
      #1;
      push(32'd1);
      push(32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("midrst_out_valid", out_valid, 64'd0);
      check_val("midrst_out_data", out_data, 64'd0);
      check_val("midrst_out_ovf_33", out_ovf_33, 64'd0);
      check_val("midrst_in_ready", in_ready, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(32'd1);
      push(32'd1);
      push(32'd1);
      check_val("post_rst_pending", out_valid, 64'd0);
      push(32'd1);
      check_val("post_rst_valid", out_valid, 64'd1);
      check_val("post_rst_data", out_data, 64'd4);
      check_val("post_rst_data_33", out_data_33, 64'd4);
      check_val("post_rst_ovf_33", out_ovf_33, 64'd0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
